// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default link parameters.
// Used by uart_rx and any sibling UART blocks.
package uart_pkg;

  localparam int CLOCK_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 Bd
  localparam int DATAWIDTH_BUS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    START     = 3'b001,
    DATA      = 3'b010,
    PARITY    = 3'b011,
    STOP      = 3'b100,
    WAIT_HIGH = 3'b101
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 1
// so an idle-high line never produces a false edge out of reset.
module uart_rx_sync (
  input  logic UART_RX_SYNC_CLOCK_50,
  input  logic UART_RX_SYNC_RESET_InHigh,
  input  logic UART_RX_SYNC_async,
  output logic UART_RX_SYNC_sync
);

  logic meta_q;

  always_ff @(posedge UART_RX_SYNC_CLOCK_50) begin
    if (UART_RX_SYNC_RESET_InHigh) begin
      meta_q            <= 1'b1;
      UART_RX_SYNC_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real shift chain;
      // blocking ones would collapse them into a single stage.
      meta_q            <= UART_RX_SYNC_async;
      UART_RX_SYNC_sync <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default; define UART_RX_PARITY_EN to add an even-parity
// bit after the data bits and the UART_RX_parityError_Out status port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = CLOCK_PER_BIT_DEFAULT,
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEFAULT,
  parameter int STATE_SIZE    = 3
) (
  input  logic                     UART_RX_CLOCK_50,
  input  logic                     UART_RX_RESET_InHigh,
  input  logic                     UART_RX_rx_In,
  output logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out,
  output logic                     UART_RX_newData_Out,
  output logic                     UART_RX_frameError_Out,
`ifdef UART_RX_PARITY_EN
  output logic                     UART_RX_parityError_Out,
`endif
  output logic                     UART_RX_busy_Out
);

  localparam int H  = CLOCK_PER_BIT / 2;
  localparam int CW = $clog2(CLOCK_PER_BIT);
  localparam int BW = $clog2(DATAWIDTH_BUS + 1);

  logic                     rx_sync, rx_s;
  logic [STATE_SIZE-1:0]    state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [DATAWIDTH_BUS-1:0] shift_q;
  logic                     cnt_clr, shift_en, deliver, frame_bad, bit_end;
`ifdef UART_RX_PARITY_EN
  logic                     par_en, par_pend_q;
`endif

  uart_rx_sync u_sync (
    .UART_RX_SYNC_CLOCK_50    (UART_RX_CLOCK_50),
    .UART_RX_SYNC_RESET_InHigh(UART_RX_RESET_InHigh),
    .UART_RX_SYNC_async       (UART_RX_rx_In),
    .UART_RX_SYNC_sync        (rx_sync)
  );

  // One extra stage keeps the FSM decision off the synchronizer output and
  // places START entry three edges after the line is first captured.
  always_ff @(posedge UART_RX_CLOCK_50) begin
    if (UART_RX_RESET_InHigh) rx_s <= 1'b1;
    else                      rx_s <= rx_sync;
  end

  assign bit_end = (cnt_q == CW'(CLOCK_PER_BIT - 1));

  always_ff @(posedge UART_RX_CLOCK_50) begin
    if (UART_RX_RESET_InHigh) state_q <= IDLE;
    else                      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(H - 1)) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;  // high at mid-start: glitch
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt_q == BW'(DATAWIDTH_BUS - 1))
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge UART_RX_CLOCK_50) begin
    if (UART_RX_RESET_InHigh) begin
      cnt_q                  <= '0;
      bit_cnt_q              <= '0;
      shift_q                <= '0;
      UART_RX_data_Out       <= '0;
      UART_RX_newData_Out    <= 1'b0;
      UART_RX_frameError_Out <= 1'b0;
      UART_RX_busy_Out       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q              <= 1'b0;
      UART_RX_parityError_Out <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + CW'(1);
      if (state_q == IDLE) bit_cnt_q <= '0;
      else if (shift_en)   bit_cnt_q <= bit_cnt_q + BW'(1);
      if (shift_en) shift_q <= {rx_s, shift_q[DATAWIDTH_BUS-1:1]};  // LSB first
      UART_RX_newData_Out <= deliver;
      if (deliver) UART_RX_data_Out <= shift_q;
      if (deliver || frame_bad) UART_RX_frameError_Out <= frame_bad;
      UART_RX_busy_Out <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      if (par_en) par_pend_q <= rx_s ^ (^shift_q);
      if (deliver || frame_bad) UART_RX_parityError_Out <= par_pend_q;
`endif
    end
  end

endmodule
